// File: rtl/rr_arbiter_4_pkg.sv
// rr_arbiter_4_pkg
//   Shared definitions for the four-requester round-robin arbiter.
//   Contents: FSM state type, requester count, and the reset value of the
//   last-grant pointer (3, so requester 0 gets first priority after reset).
package rr_arbiter_4_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } arb_state_t;

  localparam int         ARB_N_REQ = 4;
  localparam logic [1:0] LAST_RST  = 2'd3;

endpackage

// File: rtl/rr_arbiter_4_pick.sv
// rr_pick_4
//   Combinational round-robin selector. It scans REQ starting one position
//   after LAST and wraps around, so LAST itself is checked last.
// Ports:
//   REQ[3:0]      request lines, bit i = requester i
//   LAST[1:0]     index of the most recent grant
//   PICK[3:0]     one-hot selected requester, zero if REQ is zero
//   PICK_IDX[1:0] binary index of PICK (0 if REQ is zero)
module rr_pick_4
  import rr_arbiter_4_pkg::*;
(
  input  logic [3:0] REQ,
  input  logic [1:0] LAST,
  output logic [3:0] PICK,
  output logic [1:0] PICK_IDX
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    PICK     = '0;
    PICK_IDX = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      // 2-bit addition wraps modulo 4
      idx = LAST + 2'(k);
      if (!found && REQ[idx]) begin
        PICK[idx] = 1'b1;
        PICK_IDX  = idx;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4
//   Four-requester round-robin arbiter with a registered one-hot grant.
//   A requester keeps the grant until DONE or until it drops its request;
//   there is no preemption and at least one idle cycle separates grants.
//   Optional watchdog: define ARB_WATCHDOG_EN to reclaim a grant after
//   TIMEOUT cycles and pulse TIMEOUT_ERR for one cycle afterwards.
// Parameters:
//   N_REQ   number of requesters (fixed at 4)
//   TIMEOUT maximum grant length in cycles with the watchdog (2..255)
//   CNT_W   watchdog counter width, TIMEOUT < 2**CNT_W
// Ports:
//   CLK         rising-edge clock
//   RST         asynchronous active-high reset
//   REQ[3:0]    level-sensitive requests
//   DONE        holder finished, sampled only while granting
//   GNT[3:0]    registered one-hot grant, zero when idle
//   BUSY        high while a grant is held (equals |GNT)
//   TIMEOUT_ERR one-cycle pulse after a watchdog release
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int N_REQ   = ARB_N_REQ,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
)
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] REQ,
  input  logic             DONE,
  output logic [N_REQ-1:0] GNT,
  output logic             BUSY,
  output logic             TIMEOUT_ERR
);

  if (N_REQ != 4 || TIMEOUT < 2 || TIMEOUT > 255 || TIMEOUT >= (1 << CNT_W)) begin : g_cfg_err
    $error("rr_arbiter_4: illegal parameter combination");
  end

  arb_state_t state;
  logic [1:0] last;
  logic [1:0] hold_idx;
  logic [3:0] pick;
  logic [1:0] pick_idx;
  logic       rel_normal;
  logic       wd_expire;
  logic       release_now;

  rr_pick_4 u_pick (
    .REQ      (REQ),
    .LAST     (last),
    .PICK     (pick),
    .PICK_IDX (pick_idx)
  );

  // Normal release: holder finished or withdrew its request.
  assign rel_normal  = DONE | ~|(REQ & GNT);
  assign release_now = rel_normal | wd_expire;
  assign BUSY        = (state == S_GRANT);

`ifdef ARB_WATCHDOG_EN
  logic [CNT_W-1:0] wd_cnt;

  assign wd_expire = (wd_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wd_cnt      <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      TIMEOUT_ERR <= 1'b0;
      if (state == S_IDLE) begin
        wd_cnt <= '0;
      end else if (!release_now) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else if (!rel_normal) begin
        // A normal release in the same cycle takes precedence and is silent.
        TIMEOUT_ERR <= 1'b1;
      end
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign TIMEOUT_ERR = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      GNT      <= '0;
      last     <= LAST_RST;
      hold_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|REQ) begin
            GNT      <= pick;
            hold_idx <= pick_idx;
            state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (release_now) begin
            GNT   <= '0;
            last  <= hold_idx;
            state <= S_IDLE;
          end
        end
        default: begin
          GNT   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
module tb_rr_arbiter_4;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] REQ;
  logic       DONE;
  logic [3:0] GNT;
  logic       BUSY;
  logic       TIMEOUT_ERR;

  typedef struct {
    logic [3:0] gnt;
    logic       busy;
    logic       err;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   passed = 0;
  int   step_id = 0;
  bit   rand_mode = 1'b0;
  int   rand_cyc = 0;

  rr_arbiter_4 #(.N_REQ(4), .TIMEOUT(15), .CNT_W(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .REQ         (REQ),
    .DONE        (DONE),
    .GNT         (GNT),
    .BUSY        (BUSY),
    .TIMEOUT_ERR (TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int id, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s @%0d: got %b expected %b", nm, id, act, exp);
  endtask

  // Drive one cycle of inputs and queue the response expected after the edge.
  task automatic step(input logic [3:0] r, input logic d, input logic [3:0] g, input logic e);
    exp_t x;
    @(negedge CLK);
    REQ  = r;
    DONE = d;
    step_id++;
    x.gnt  = g;
    x.busy = |g;
    x.err  = e;
    x.id   = step_id;
    exp_q.push_back(x);
  endtask

  // Monitor: compares the DUT against the queued expectation after each edge.
  always @(posedge CLK) begin
    exp_t x;
    #1;
    if (rand_mode) begin
      rand_cyc++;
      chk("onehot0", rand_cyc, {3'b000, $onehot0(GNT)}, 4'd1);
      chk("busy_eq_or", rand_cyc, {3'b000, BUSY}, {3'b000, |GNT});
    end else if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("gnt", x.id, GNT, x.gnt);
      chk("busy", x.id, {3'b000, BUSY}, {3'b000, x.busy});
      chk("timeout_err", x.id, {3'b000, TIMEOUT_ERR}, {3'b000, x.err});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL time_limit: simulation did not finish, got running expected done");
    $fatal(1, "time limit");
  end

  initial begin
    RST  = 1'b1;
    REQ  = 4'b0000;
    DONE = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_gnt", 0, GNT, 4'b0000);
    chk("rst_busy", 0, {3'b000, BUSY}, 4'd0);
    chk("rst_err", 0, {3'b000, TIMEOUT_ERR}, 4'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Two requesters, pointer moves to the granted one
    step(4'b1010, 1'b0, 4'b0010, 1'b0);
    step(4'b1010, 1'b1, 4'b0000, 1'b0);
    step(4'b1010, 1'b0, 4'b1000, 1'b0);
    step(4'b1010, 1'b1, 4'b0000, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);

    // All requesting: full rotation with one idle cycle between grants
    step(4'b1111, 1'b0, 4'b0001, 1'b0);
    step(4'b1111, 1'b1, 4'b0000, 1'b0);
    step(4'b1111, 1'b0, 4'b0010, 1'b0);
    step(4'b1111, 1'b1, 4'b0000, 1'b0);
    step(4'b1111, 1'b0, 4'b0100, 1'b0);
    step(4'b1111, 1'b1, 4'b0000, 1'b0);
    step(4'b1111, 1'b0, 4'b1000, 1'b0);
    step(4'b1111, 1'b1, 4'b0000, 1'b0);
    step(4'b1111, 1'b0, 4'b0001, 1'b0);
    step(4'b1111, 1'b1, 4'b0000, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);

    // No preemption, then holder 2 drops its request
    step(4'b0100, 1'b0, 4'b0100, 1'b0);
    step(4'b1111, 1'b0, 4'b0100, 1'b0);
    step(4'b1011, 1'b0, 4'b0000, 1'b0);
    step(4'b1011, 1'b0, 4'b1000, 1'b0);
    step(4'b1011, 1'b1, 4'b0000, 1'b0);

    // Lone requester is re-granted; DONE with REQ drop is one release
    step(4'b1000, 1'b0, 4'b1000, 1'b0);
    step(4'b1000, 1'b1, 4'b0000, 1'b0);
    step(4'b1000, 1'b0, 4'b1000, 1'b0);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);

    // DONE ignored while idle
    step(4'b0001, 1'b1, 4'b0001, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);

`ifdef ARB_WATCHDOG_EN
    for (int i = 0; i < 15; i++) step(4'b0001, 1'b0, 4'b0001, 1'b0);
    step(4'b0001, 1'b0, 4'b0000, 1'b1);
    step(4'b0001, 1'b0, 4'b0001, 1'b0);
    for (int i = 0; i < 14; i++) step(4'b0001, 1'b0, 4'b0001, 1'b0);
    step(4'b0001, 1'b1, 4'b0000, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);
`else
    for (int i = 0; i < 25; i++) step(4'b0001, 1'b0, 4'b0001, 1'b0);
    step(4'b0001, 1'b1, 4'b0000, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);
`endif

    // Asynchronous reset in the middle of a grant
    step(4'b0100, 1'b0, 4'b0100, 1'b0);
    @(posedge CLK);
    #1;
    while (exp_q.size() > 0) #1;
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_gnt", step_id, GNT, 4'b0000);
    chk("async_rst_busy", step_id, {3'b000, BUSY}, 4'd0);
    REQ = 4'b0101;
    @(negedge CLK);
    RST = 1'b0;
    step(4'b0101, 1'b0, 4'b0001, 1'b0);
    step(4'b0101, 1'b1, 4'b0000, 1'b0);
    step(4'b0101, 1'b0, 4'b0100, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);
    @(posedge CLK);
    #2;

    // Random traffic: structural invariants only
    @(negedge CLK);
    rand_mode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      REQ  = 4'($urandom);
      DONE = ($urandom_range(0, 3) == 0);
      @(negedge CLK);
    end
    rand_mode = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
